mil_push_fifo: RTL and testbench
================================

MIL_PUSH_FIFO -- requirements
Module: mil_push_fifo

Interface
REQ-001 Parameter DEPTH, default 8: number of buffered MIL words; power of two, 2..256.
REQ-002 Parameter DROP_ERRORS, default 1: when 1, words of type WERROR are discarded at input.
REQ-003 Parameter TIMEOUT, default 1024: cycles to wait for out_done before the request is reissued.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  synchronous clear of buffer contents and output FSM.
REQ-007 in_request  in  1  one-cycle push strobe; in_type/in_data valid in the same cycle.
REQ-008 in_type  in  milStd1553::WordType  type of the pushed word.
REQ-009 in_data  in  16  pushed data word.
REQ-010 in_done  out  1  one-cycle completion pulse to the producer.
REQ-011 out_request  out  1  one-cycle request strobe to the downstream consumer.
REQ-012 out_type / out_data  out  WordType / 16  head word; stable from out_request until out_done.
REQ-013 out_done  in  1  downstream completion pulse.
REQ-014 level  out  $clog2(DEPTH)+1  words stored; empty and full are 1-bit outputs derived from level.
REQ-015 overflow_cnt / drop_cnt / retry_cnt  out  16 each  saturating event counters.

Function
REQ-016 Every in_request SHALL produce exactly one in_done pulse in the following cycle, whether the word is stored or discarded, so the producer never stalls.
REQ-017 A word SHALL be stored when in_request=1, flush=0, full=0 and not (DROP_ERRORS=1 and in_type=WERROR).
REQ-018 in_request with full=1 SHALL discard the word and increment overflow_cnt; full is evaluated on the registered level, so a same-cycle pop does not admit the push.
REQ-019 A WERROR word with DROP_ERRORS=1 SHALL be discarded and increment drop_cnt; with DROP_ERRORS=0 it SHALL be stored like any other word.
REQ-020 Output FSM states: IDLE, REQ, WAIT.
REQ-021 IDLE -> REQ when empty=0; REQ SHALL assert out_request for exactly one cycle, then go to WAIT.
REQ-022 WAIT -> IDLE on out_done=1; the head word is popped in that same cycle.
REQ-023 WAIT -> REQ when TIMEOUT cycles elapse without out_done; retry_cnt SHALL increment and the same head word SHALL be reissued.
REQ-024 Minimum word-to-word interval on the output SHALL be 3 cycles (REQ, WAIT with done, IDLE).
REQ-025 A push and a pop in the same cycle SHALL leave level unchanged; pointers SHALL wrap modulo DEPTH.
REQ-026 Order SHALL be strict FIFO; words SHALL NOT be duplicated except by retry.
REQ-027 flush=1 SHALL set level=0, reset both pointers, and force the FSM to IDLE with out_request=0.
REQ-028 flush=1 SHALL NOT clear the counters.
REQ-029 A push coinciding with flush SHALL be discarded, pulse in_done, and not be counted.
REQ-030 out_done arriving outside WAIT SHALL be ignored.
REQ-031 All counters SHALL saturate at 16'hFFFF.
REQ-032 Each counter SHALL increment by at most 1 per cycle.

Reset
REQ-033 rst SHALL take priority over flush and all other inputs.
REQ-034 After rst: level=0, empty=1, full=0, in_done=0, out_request=0, FSM=IDLE.
REQ-035 After rst: overflow_cnt=0, drop_cnt=0, retry_cnt=0.
REQ-036 After rst: out_type=WDATA, out_data=16'h0000.
REQ-037 rst mid-transaction SHALL abandon any outstanding request without issuing in_done for it.

Structure
REQ-038 WordType and the {dataType, dataWord} struct SHALL come from package milStd1553; no new package types are needed.
REQ-039 The FSM state enum SHALL be local to the module.
REQ-040 Storage SHALL be a sub-module mil_fifo_mem: DEPTH x (WordType+16) bits, one write port, one asynchronous read port, no reset on the array.

Verification
REQ-041 rst, then push WCOMMAND 16'h1234, WDATA 16'hABCD; consumer answers out_done 2 cycles after each out_request -> same two words out, in order; level returns to 0.
REQ-042 DEPTH=8, consumer silent, 10 pushes -> level=8, full=1, overflow_cnt=2, 10 in_done pulses.
REQ-043 DROP_ERRORS=1: push WERROR 16'h0BAD -> drop_cnt=1, level=0, no out_request.
REQ-043a DROP_ERRORS=0: push WERROR 16'h0BAD -> word appears at output.
REQ-044 TIMEOUT=16, one word, no out_done for 40 cycles -> out_request pulses at offsets 0, 17, 34; retry_cnt=2; then out_done -> pop, level=0.
REQ-045 Level 5 in WAIT, assert flush one cycle -> level=0, out_request=0, FSM IDLE, counters unchanged.
REQ-045a Next push after flush appears at the output first.

Source files
------------

// File: rtl/mil_push_fifo_pkg.sv
// milStd1553 -- shared MIL-STD-1553 word types for the push FIFO slice.
//   WordType : 2-bit classification of a received/transmitted 1553 word
//   MilData  : packed {dataType, dataWord} pair as stored in buffers
//   sat_inc16: saturating increment used by the event counters
package milStd1553;

    typedef enum logic [1:0] {
        WERROR   = 2'd0,
        WCOMMAND = 2'd1,
        WSTATUS  = 2'd2,
        WDATA    = 2'd3
    } WordType;

    typedef struct packed {
        WordType     dataType;
        logic [15:0] dataWord;
    } MilData;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mil_push_fifo_mem.sv
// mil_fifo_mem -- word storage for mil_push_fifo.
//   clk   : write clock
//   we    : write enable, writes wdata at waddr on the rising edge
//   raddr : read address, rdata follows it combinationally
// The array has no reset; the FIFO pointers/level define what is valid.
module mil_fifo_mem
    import milStd1553::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  MilData                   wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output MilData                   rdata
);

    MilData mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mil_push_fifo.sv
// mil_push_fifo -- fire-and-forget MIL word buffer with a request/done
// handshake toward the consumer and timeout-driven reissue.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : clears contents and output FSM, keeps counters
//   in_request/type/data: one-cycle push; in_done pulses the next cycle
//   out_request         : one-cycle strobe per (re)issue of the head word
//   out_type/out_data   : head word, held from out_request until out_done
//   out_done            : consumer completion, honoured only while waiting
//   level/empty/full    : occupancy
//   overflow/drop/retry_cnt : saturating event counters
module mil_push_fifo
    import milStd1553::*;
#(
    parameter int DEPTH       = 8,
    parameter int DROP_ERRORS = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_request,
    input  WordType                in_type,
    input  logic [15:0]            in_data,
    output logic                   in_done,
    output logic                   out_request,
    output WordType                out_type,
    output logic [15:0]            out_data,
    input  logic                   out_done,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic [15:0]            overflow_cnt,
    output logic [15:0]            drop_cnt,
    output logic [15:0]            retry_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t         state_reg, state_next;
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]  level_reg;
    logic [TW-1:0]  timer_reg;
    logic           in_done_reg;
    WordType        out_type_reg;
    logic [15:0]    out_data_reg;
    logic [15:0]    overflow_cnt_reg, drop_cnt_reg, retry_cnt_reg;

    MilData         head_word;
    logic           drop_hit, overflow_hit, push;
    logic           pop, timeout_hit, load_head;

    assign empty = (level_reg == '0);
    assign full  = (level_reg == LW'(DEPTH));

    // An error word is filtered before the buffer is consulted, so with
    // DROP_ERRORS set it counts as a drop even when the buffer is full.
    // A push during flush is swallowed without touching any counter.
    assign drop_hit     = in_request && !flush && (DROP_ERRORS != 0) && (in_type == WERROR);
    assign overflow_hit = in_request && !flush && !drop_hit && full;
    assign push         = in_request && !flush && !drop_hit && !full;

    mil_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata (MilData'{dataType: in_type, dataWord: in_data}),
        .raddr (rd_ptr_reg),
        .rdata (head_word)
    );

    // Output FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Output FSM: next state
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (!empty) state_next = REQ;
            REQ:     state_next = WAIT;
            WAIT: begin
                if (out_done)         state_next = IDLE;
                else if (timeout_hit) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Output FSM: outputs and handshake events
    always_comb begin
        out_request = (state_reg == REQ);
        pop         = (state_reg == WAIT) && out_done && !flush;
        timeout_hit = (state_reg == WAIT) && !out_done && (timer_reg == TW'(TIMEOUT - 1));
        load_head   = (state_reg == IDLE) && !empty && !flush;
    end

    // Wait timer counts cycles spent in WAIT since the last (re)issue.
    always_ff @(posedge clk) begin
        if (rst || flush || state_reg != WAIT) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            level_reg        <= '0;
            in_done_reg      <= 1'b0;
            out_type_reg     <= WDATA;
            out_data_reg     <= 16'h0000;
            overflow_cnt_reg <= 16'h0000;
            drop_cnt_reg     <= 16'h0000;
            retry_cnt_reg    <= 16'h0000;
        end else begin
            in_done_reg <= in_request;
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                level_reg  <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
                if (push && !pop)      level_reg <= level_reg + LW'(1);
                else if (pop && !push) level_reg <= level_reg - LW'(1);
            end
            // Head is captured once on IDLE->REQ; a reissue keeps it as is.
            if (load_head) begin
                out_type_reg <= head_word.dataType;
                out_data_reg <= head_word.dataWord;
            end
            if (overflow_hit) overflow_cnt_reg <= sat_inc16(overflow_cnt_reg);
            if (drop_hit)     drop_cnt_reg     <= sat_inc16(drop_cnt_reg);
            if (timeout_hit)  retry_cnt_reg    <= sat_inc16(retry_cnt_reg);
        end
    end

    assign in_done      = in_done_reg;
    assign out_type     = out_type_reg;
    assign out_data     = out_data_reg;
    assign level        = level_reg;
    assign overflow_cnt = overflow_cnt_reg;
    assign drop_cnt     = drop_cnt_reg;
    assign retry_cnt    = retry_cnt_reg;

endmodule

// File: tb/tb_mil_push_fifo.sv
// tb_mil_push_fifo -- randomized and directed bench for mil_push_fifo.
// Reference: a queue of stored words plus a consumer that answers each
// request after a chosen delay; expected retries follow from that delay.
module tb_mil_push_fifo;
    import milStd1553::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_request, out_done;
    WordType     in_type;
    logic [15:0] in_data;

    logic        in_done, out_request, empty, full;
    WordType     out_type;
    logic [15:0] out_data, overflow_cnt, drop_cnt, retry_cnt;
    logic [3:0]  level;

    logic        in_done_e, out_request_e, empty_e, full_e;
    WordType     out_type_e;
    logic [15:0] out_data_e, overflow_cnt_e, drop_cnt_e, retry_cnt_e;
    logic [3:0]  level_e;

    mil_push_fifo #(.DEPTH(DEPTH), .DROP_ERRORS(1), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_request(in_request),
        .in_type(in_type), .in_data(in_data), .in_done(in_done),
        .out_request(out_request), .out_type(out_type), .out_data(out_data),
        .out_done(out_done), .level(level), .empty(empty), .full(full),
        .overflow_cnt(overflow_cnt), .drop_cnt(drop_cnt), .retry_cnt(retry_cnt)
    );

    // Second instance keeps error words; only used for the error-pass case.
    mil_push_fifo #(.DEPTH(DEPTH), .DROP_ERRORS(0), .TIMEOUT(TMO)) dut_keep (
        .clk(clk), .rst(rst), .flush(flush), .in_request(in_request),
        .in_type(in_type), .in_data(in_data), .in_done(in_done_e),
        .out_request(out_request_e), .out_type(out_type_e), .out_data(out_data_e),
        .out_done(out_done), .level(level_e), .empty(empty_e), .full(full_e),
        .overflow_cnt(overflow_cnt_e), .drop_cnt(drop_cnt_e), .retry_cnt(retry_cnt_e)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    MilData      q[$];
    int          m_ovf, m_drop, m_retry;
    bit          outstanding;
    int          elapsed, cons_dly, cons_mode, fixed_dly, gap, cyc, done_pulses;
    int          req_log[$];
    logic [15:0] last_req_data;

    // One clock cycle: drive inputs, advance the model, sample after the edge.
    task automatic step(input bit req, input WordType t, input logic [15:0] d, input bit fl);
        bit dn;
        bit was_full;
        dn = 1'b0;
        if (outstanding && elapsed == cons_dly && cons_dly <= TMO) dn = 1'b1;
        else if (!outstanding && cons_mode == 0 && $urandom_range(0, 15) == 0) dn = 1'b1;
        in_request = req; in_type = t; in_data = d; flush = fl; out_done = dn;

        if (fl) begin
            q.delete();
            outstanding = 1'b0;
            elapsed = 0;
        end else begin
            was_full = (q.size() == DEPTH);
            if (dn && outstanding) begin
                void'(q.pop_front());
                outstanding = 1'b0;
            end
            if (req) begin
                if (t == WERROR)    m_drop++;
                else if (was_full)  m_ovf++;
                else                q.push_back(MilData'{dataType: t, dataWord: d});
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        in_request = 1'b0; out_done = 1'b0; flush = 1'b0;

        check_eq("in_done", in_done, req);
        if (in_done) done_pulses++;
        check_eq("level", level, q.size());
        check_eq("empty_full", {empty, full}, {q.size() == 0, q.size() == DEPTH});
        check_eq("overflow_cnt", overflow_cnt, m_ovf);
        check_eq("drop_cnt", drop_cnt, m_drop);

        if (outstanding) begin
            elapsed++;
            if (elapsed == TMO + 1) begin
                m_retry++;
                check_eq("retry_due", out_request, 1);
            end else begin
                check_eq("no_early_req", out_request, 0);
            end
        end
        check_eq("retry_cnt", retry_cnt, m_retry);

        if (out_request) begin
            req_log.push_back(cyc);
            last_req_data = out_data;
            check_eq("req_has_word", q.size() != 0, 1);
            if (q.size() != 0) begin
                check_eq("out_type", out_type, q[0].dataType);
                check_eq("out_data", out_data, q[0].dataWord);
            end
            outstanding = 1'b1;
            elapsed = 0;
            cons_dly = (cons_mode == 0) ? int'($urandom_range(1, 24)) :
                       (cons_mode == 1) ? fixed_dly : 999;
            gap = 0;
        end else if (!outstanding && q.size() != 0) begin
            gap++;
            check_eq("req_latency_ok", gap <= 1, 1);
        end else begin
            gap = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, WDATA, 16'h0000, 1'b0);
    endtask

    task automatic push(input WordType t, input logic [15:0] d);
        step(1'b1, t, d, 1'b0);
    endtask

    // Reset with a push pending on the reset edge: it must not produce in_done.
    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; out_done = 1'b0;
        in_request = 1'b1; in_type = WDATA; in_data = 16'h7777;
        @(posedge clk);
        in_request = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete(); req_log.delete();
        m_ovf = 0; m_drop = 0; m_retry = 0;
        outstanding = 1'b0; elapsed = 0; gap = 0; done_pulses = 0;
        cons_mode = 2; fixed_dly = 2; cons_dly = 999;
    endtask

    initial begin
        int          c0;
        bit          seen;
        logic [15:0] o_ovf, o_drp, o_rty;

        rst = 1'b1; flush = 1'b0; in_request = 1'b0; out_done = 1'b0;
        in_type = WDATA; in_data = 16'h0000; cyc = 0; last_req_data = 16'h0000;

        // Reset state
        do_reset();
        check_eq("rst_level", level, 0);
        check_eq("rst_empty_full", {empty, full}, 2'b10);
        check_eq("rst_in_done", in_done, 0);
        check_eq("rst_out_request", out_request, 0);
        check_eq("rst_counters", {overflow_cnt, drop_cnt, retry_cnt}, 48'h0);
        check_eq("rst_out_type", out_type, WDATA);
        check_eq("rst_out_data", out_data, 16'h0000);

        // Two words, consumer answers 2 cycles after each request
        cons_mode = 1; fixed_dly = 2;
        push(WCOMMAND, 16'h1234);
        push(WDATA, 16'hABCD);
        idle(12);
        check_eq("two_words_reqs", req_log.size(), 2);
        check_eq("two_words_level", level, 0);

        // Fill past capacity with a silent consumer
        do_reset();
        for (int i = 0; i < 10; i++) push(WDATA, 16'h0100 + 16'(i));
        check_eq("fill_level", level, 8);
        check_eq("fill_full", full, 1);
        check_eq("fill_overflow", overflow_cnt, 2);
        check_eq("fill_done_pulses", done_pulses, 10);

        // Error word dropped / kept
        do_reset();
        push(WERROR, 16'h0BAD);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_request_e && !seen) begin
                seen = 1'b1;
                check_eq("keep_err_type", out_type_e, WERROR);
                check_eq("keep_err_data", out_data_e, 16'h0BAD);
            end
            idle(1);
        end
        check_eq("keep_err_seen", seen, 1);
        check_eq("drop_err_cnt", drop_cnt, 1);
        check_eq("drop_err_level", level, 0);
        check_eq("drop_err_noreq", req_log.size(), 0);

        // Timeout reissue at offsets 0, 17, 34
        do_reset();
        push(WCOMMAND, 16'h4444);
        idle(2);
        c0 = (req_log.size() > 0) ? req_log[0] : cyc;
        for (int i = 0; i < 60 && cyc < c0 + 40; i++) idle(1);
        check_eq("retry_reqs", req_log.size(), 3);
        if (req_log.size() == 3) begin
            check_eq("retry_off1", req_log[1] - req_log[0], 17);
            check_eq("retry_off2", req_log[2] - req_log[0], 34);
        end
        check_eq("retry_count", retry_cnt, 2);
        cons_dly = elapsed;
        idle(3);
        check_eq("retry_pop_level", level, 0);

        // Flush with 5 words while waiting
        do_reset();
        for (int i = 0; i < 5; i++) push(WSTATUS, 16'h2000 + 16'(i));
        idle(1);
        check_eq("pre_flush_level", level, 5);
        o_ovf = overflow_cnt; o_drp = drop_cnt; o_rty = retry_cnt;
        step(1'b0, WDATA, 16'h0000, 1'b1);
        check_eq("flush_level", level, 0);
        check_eq("flush_out_request", out_request, 0);
        idle(2);
        check_eq("flush_counters", {overflow_cnt, drop_cnt, retry_cnt}, {o_ovf, o_drp, o_rty});
        cons_mode = 1; fixed_dly = 3;
        req_log.delete();
        push(WDATA, 16'h5A5A);
        idle(8);
        check_eq("post_flush_reqs", req_log.size(), 1);
        check_eq("post_flush_word", last_req_data, 16'h5A5A);

        // Randomized traffic
        do_reset();
        cons_mode = 0;
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) < 45, WordType'($urandom_range(0, 3)),
                 16'($urandom), $urandom_range(0, 299) == 0);
        end
        cons_mode = 1; fixed_dly = 1;
        idle(40);
        check_eq("rand_drain_level", level, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
